// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types, region constants and decode for the 8088 bus cycle controller
package bus_ctrl_pkg;

  // One-hot controller states
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_WAIT = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  localparam logic [1:0] REG_MEM0 = 2'd0;
  localparam logic [1:0] REG_MEM1 = 2'd1;
  localparam logic [1:0] REG_IO0  = 2'd2;
  localparam logic [1:0] REG_IO1  = 2'd3;

  // Memory cycles split on A[19], I/O cycles split on A[15]
  function automatic logic [1:0] decode_region(input logic iom, input logic [19:0] a);
    if (iom) begin
      return a[15] ? REG_IO1 : REG_IO0;
    end
    return a[19] ? REG_MEM1 : REG_MEM0;
  endfunction

  function automatic logic [3:0] region_onehot(input logic [1:0] region);
    return 4'b0001 << region;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// rtl/bus_cycle_ctrl_if.sv - 8088 bus pins plus peripheral select/ready signals
interface bus_cycle_ctrl_if;
  logic        ALE;
  logic        IOM;
  logic        RD_N;
  logic        WR_N;
  logic [19:0] A;
  logic [3:0]  CS;
  logic        READY;
  logic        BUSY;
  logic        ERR;
  logic [1:0]  REGION;

  modport master (
    output ALE, IOM, RD_N, WR_N, A,
    input  CS, READY, BUSY, ERR, REGION
  );

  modport slave (
    input  ALE, IOM, RD_N, WR_N, A,
    output CS, READY, BUSY, ERR, REGION
  );
endinterface

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - loadable down-counter with zero flag
module bus_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 8088 bus cycle sequencer: region decode, chip select, wait states, error flag
module bus_cycle_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MEM0 = 0,
  parameter int unsigned WAIT_MEM1 = 1,
  parameter int unsigned WAIT_IO0  = 2,
  parameter int unsigned WAIT_IO1  = 3,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic             CLK,
  input logic             RESET_N,
  bus_cycle_ctrl_if.slave bus
);

  // The wait counter is 4 bits and the timeout counter 8 bits wide
  if (WAIT_MEM0 > 15 || WAIT_MEM1 > 15 || WAIT_IO0 > 15 || WAIT_IO1 > 15) begin : g_bad_wait
    $error("bus_cycle_ctrl: wait-state parameters must be 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_cycle_ctrl: TIMEOUT must be 1..255");
  end

  localparam logic [3:0] W_MEM0       = 4'(WAIT_MEM0);
  localparam logic [3:0] W_MEM1       = 4'(WAIT_MEM1);
  localparam logic [3:0] W_IO0        = 4'(WAIT_IO0);
  localparam logic [3:0] W_IO1        = 4'(WAIT_IO1);
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT);

  state_t     state;
  logic [3:0] cs_q;
  logic       ready_q;
  logic       busy_q;
  logic       err_q;
  logic [1:0] region_q;

  logic [1:0] new_region;
  logic [3:0] wait_n;
  logic [3:0] wait_value;
  logic       both_low;
  logic       one_low;
  logic       tmo_load;
  logic       tmo_dec;
  logic       tmo_zero;
  logic       wait_load;
  logic       wait_dec;
  logic       wait_zero;

  // Strobe qualification, region decode and per-region wait count
  always_comb begin
    both_low   = !bus.RD_N && !bus.WR_N;
    one_low    = bus.RD_N ^ bus.WR_N;
    new_region = decode_region(bus.IOM, bus.A);
    case (region_q)
      REG_MEM0: wait_n = W_MEM0;
      REG_MEM1: wait_n = W_MEM1;
      REG_IO0:  wait_n = W_IO0;
      default:  wait_n = W_IO1;
    endcase
    // WAIT is entered with READY already low, so it lasts N-1 further edges
    wait_value = (wait_n == 4'd0) ? 4'd0 : wait_n - 4'd1;
  end

  // Counter controls: timeout armed on ALE, wait count armed on the accepted strobe
  always_comb begin
    tmo_load  = (state == S_IDLE) && bus.ALE;
    tmo_dec   = (state == S_ADDR);
    wait_load = (state == S_ADDR) && one_low && (wait_n != 4'd0);
    wait_dec  = (state == S_WAIT);
  end

  bus_wait_counter #(.WIDTH(8)) u_timeout (
    .clk        (CLK),
    .reset_n    (RESET_N),
    .load       (tmo_load),
    .load_value (TIMEOUT_LOAD),
    .dec        (tmo_dec),
    .zero       (tmo_zero)
  );

  bus_wait_counter #(.WIDTH(4)) u_wait (
    .clk        (CLK),
    .reset_n    (RESET_N),
    .load       (wait_load),
    .load_value (wait_value),
    .dec        (wait_dec),
    .zero       (wait_zero)
  );

  // Bus cycle FSM with registered outputs; ERR defaults low so it only pulses
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      cs_q     <= 4'b0000;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      region_q <= REG_MEM0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ALE) begin
            region_q <= new_region;
            cs_q     <= region_onehot(new_region);
            busy_q   <= 1'b1;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (both_low || (!one_low && tmo_zero)) begin
            err_q   <= 1'b1;
            cs_q    <= 4'b0000;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else if (one_low) begin
            if (wait_n == 4'd0) begin
              state <= S_DONE;
            end else begin
              ready_q <= 1'b0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (both_low) begin
            err_q   <= 1'b1;
            cs_q    <= 4'b0000;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else if (wait_zero) begin
            ready_q <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          if (bus.RD_N && bus.WR_N) begin
            cs_q   <= 4'b0000;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          cs_q    <= 4'b0000;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.CS     = cs_q;
  assign bus.READY  = ready_q;
  assign bus.BUSY   = busy_q;
  assign bus.ERR    = err_q;
  assign bus.REGION = region_q;

endmodule
